// File: rtl/dmem_dma_bridge.sv
// DMEM port arbiter: the CPU always wins, and stream-DMA writes fill idle RAM cycles.
// Define DMEM_DMA_BYTESWAP_EN to byte-swap each DMA word before it is written.
module dmem_dma_bridge #(
   parameter int ADDR_MSB   = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              mclk,
   input  logic              puc_rst,
   input  logic [ADDR_MSB:0] cpu_dmem_addr,
   input  logic              cpu_dmem_cen,
   input  logic [15:0]       cpu_dmem_din,
   input  logic [1:0]        cpu_dmem_wen,
   output logic [15:0]       cpu_dmem_dout,
   input  logic              dma_start,
   input  logic [ADDR_MSB:0] dma_base_addr,
   input  logic [ADDR_MSB+1:0] dma_len,
   input  logic              s_valid,
   input  logic [15:0]       s_data,
   output logic              s_ready,
   output logic              dma_busy,
   output logic              dma_done,
   output logic [ADDR_MSB:0] ram_addr,
   output logic              ram_cen,
   output logic [15:0]       ram_din,
   output logic [1:0]        ram_wen,
   input  logic [15:0]       ram_dout
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [ADDR_MSB+1:0] len_q;
   logic [ADDR_MSB+1:0] acc_cnt;
   logic [ADDR_MSB+1:0] wr_cnt;
   logic [ADDR_MSB:0]   addr_q;
   logic [15:0]         fifo [FIFO_DEPTH];
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [PW:0]         count;
   logic                run;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                last_wr;
   logic [15:0]         head;
   logic [15:0]         wdata;

   assign run     = (state == RUN);
   assign full    = (count == (PW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign s_ready = run && !full && (acc_cnt < len_q);
   assign push    = s_valid && s_ready;
   // A DMA write only happens when the CPU leaves the RAM alone.
   assign pop     = run && !empty && cpu_dmem_cen;
   assign last_wr = pop && (wr_cnt == len_q - 1'b1);
   assign head    = fifo[rd_ptr];

`ifdef DMEM_DMA_BYTESWAP_EN
   assign wdata = {head[7:0], head[15:8]};
`else
   assign wdata = head;
`endif

   assign dma_busy      = run;
   assign cpu_dmem_dout = ram_dout;

   always_comb begin
      ram_addr = cpu_dmem_addr;
      ram_din  = cpu_dmem_din;
      ram_cen  = 1'b1;
      ram_wen  = 2'b11;
      if (!cpu_dmem_cen) begin
         ram_cen = 1'b0;
         ram_wen = cpu_dmem_wen;
      end else if (pop) begin
         ram_addr = addr_q;
         ram_din  = wdata;
         ram_cen  = 1'b0;
         ram_wen  = 2'b00;
      end
   end

   always_ff @(posedge mclk) begin
      if (push) fifo[wr_ptr] <= s_data;
   end

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         state    <= IDLE;
         dma_done <= 1'b0;
         len_q    <= '0;
         acc_cnt  <= '0;
         wr_cnt   <= '0;
         addr_q   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         dma_done <= 1'b0;
         case (state)
            IDLE: begin
               if (dma_start) begin
                  if (dma_len != '0) begin
                     len_q   <= dma_len;
                     addr_q  <= dma_base_addr;
                     acc_cnt <= '0;
                     wr_cnt  <= '0;
                     rd_ptr  <= '0;
                     wr_ptr  <= '0;
                     count   <= '0;
                     state   <= RUN;
                  end else begin
                     dma_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (push) begin
                  acc_cnt <= acc_cnt + 1'b1;
                  wr_ptr  <= wr_ptr + 1'b1;
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  addr_q <= addr_q + 1'b1;
                  wr_cnt <= wr_cnt + 1'b1;
               end
               if (push && !pop) count <= count + 1'b1;
               if (pop && !push) count <= count - 1'b1;
               if (last_wr) begin
                  state    <= IDLE;
                  dma_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_dma_bridge.sv
// Self-checking bench for dmem_dma_bridge: behavioural RAM plus an expected memory image.
// Build with DMEM_DMA_BYTESWAP_EN to exercise the byte-swapped write path.
module tb_dmem_dma_bridge;

   localparam int AM = 9;
   localparam int N  = 1024;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [9:0]  cpu_dmem_addr;
   logic        cpu_dmem_cen;
   logic [15:0] cpu_dmem_din;
   logic [1:0]  cpu_dmem_wen;
   logic [15:0] cpu_dmem_dout;
   logic        dma_start;
   logic [9:0]  dma_base_addr;
   logic [10:0] dma_len;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        dma_busy;
   logic        dma_done;
   logic [9:0]  ram_addr;
   logic        ram_cen;
   logic [15:0] ram_din;
   logic [1:0]  ram_wen;
   logic [15:0] ram_dout;

   logic        clr;
   logic [15:0] mem [N];
   logic [15:0] exp_mem [N];
   logic [15:0] wq [$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int dma_wr_n = 0;
   int done_n = 0;
   int last_wr_cyc = 0;
   int done_cyc = 0;
   logic done_busy = 1'b0;

   always #5 mclk = ~mclk;

   dmem_dma_bridge #(.ADDR_MSB(AM), .FIFO_DEPTH(4)) dut (
      .mclk(mclk), .puc_rst(puc_rst),
      .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_cen(cpu_dmem_cen),
      .cpu_dmem_din(cpu_dmem_din), .cpu_dmem_wen(cpu_dmem_wen),
      .cpu_dmem_dout(cpu_dmem_dout),
      .dma_start(dma_start), .dma_base_addr(dma_base_addr), .dma_len(dma_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .dma_busy(dma_busy), .dma_done(dma_done),
      .ram_addr(ram_addr), .ram_cen(ram_cen), .ram_din(ram_din),
      .ram_wen(ram_wen), .ram_dout(ram_dout)
   );

   // Single-port synchronous RAM with per-byte write enables.
   always @(posedge mclk) begin
      if (clr) begin
         for (int i = 0; i < N; i++) mem[i] <= 16'h0000;
      end else if (!ram_cen) begin
         if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
         if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
         ram_dout <= mem[ram_addr];
      end
   end

   // Event monitor, sampled mid-cycle.
   always @(negedge mclk) begin
      if (!ram_cen && cpu_dmem_cen) begin
         dma_wr_n++;
         last_wr_cyc = cyc;
      end
      if (dma_done) begin
         done_n++;
         done_cyc  = cyc;
         done_busy = dma_busy;
      end
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   function automatic logic [15:0] dma_word(input logic [15:0] w);
`ifdef DMEM_DMA_BYTESWAP_EN
      return {w[7:0], w[15:8]};
`else
      return w;
`endif
   endfunction

   task automatic cpu_model_write(input logic [9:0] a, input logic [15:0] d,
                                  input logic [1:0] wen);
      if (!wen[0]) exp_mem[a][7:0]  = d[7:0];
      if (!wen[1]) exp_mem[a][15:8] = d[15:8];
   endtask

   task automatic start(input logic [9:0] b, input logic [10:0] l);
      dma_base_addr = b;
      dma_len       = l;
      dma_start     = 1'b1;
      tick();
      dma_start     = 1'b0;
      dma_base_addr = 10'($urandom);
      dma_len       = 11'($urandom);
   endtask

   task automatic push(input logic [15:0] w, input logic [9:0] a,
                       input bit upd);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = w;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge mclk);
         if (s_ready) ok = 1'b1;
      end
      if (ok) tick();
      s_valid = 1'b0;
      s_data  = 16'($urandom);
      chk("push_accept", 32'(ok), 32'd1);
      if (ok && upd) exp_mem[a] = dma_word(w);
   endtask

   task automatic wait_done(input int n0);
      int i;
      i = 0;
      while (done_n == n0 && i < 300) begin
         @(negedge mclk);
         i++;
      end
      chk("done_seen", 32'(done_n != n0), 32'd1);
   endtask

   task automatic xfer_check(input logic [9:0] b, input int l,
                             input int n0, input int w0);
      wait_done(n0);
      repeat (3) tick();
      chk("done_once", 32'(done_n - n0), 32'd1);
      chk("write_count", 32'(dma_wr_n - w0), 32'(l));
      chk("done_after_last_write", 32'(done_cyc - last_wr_cyc), 32'd1);
      chk("busy_low_at_done", 32'(done_busy), 32'd0);
      for (int i = 0; i < l; i++)
         chk("ram_word", 32'(mem[10'(b + i)]), 32'(exp_mem[10'(b + i)]));
   endtask

   task automatic xfer(input logic [9:0] b, input int l, input bit gaps);
      int n0;
      int w0;
      logic [15:0] w;
      n0 = done_n;
      w0 = dma_wr_n;
      start(b, 11'(l));
      for (int i = 0; i < l; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         if (wq.size() != 0) w = wq.pop_front();
         else w = 16'($urandom);
         push(w, 10'(b + i), 1'b1);
      end
      @(negedge mclk);
      chk("ready_low_at_len", 32'(s_ready), 32'd0);
      xfer_check(b, l, n0, w0);
   endtask

   initial begin
      int n0;
      int w0;
      int snap;
      int bad;
      logic [15:0] d;
      logic [1:0]  we;

      puc_rst       = 1'b1;
      clr           = 1'b1;
      cpu_dmem_addr = '0;
      cpu_dmem_cen  = 1'b1;
      cpu_dmem_din  = '0;
      cpu_dmem_wen  = 2'b11;
      dma_start     = 1'b0;
      dma_base_addr = '0;
      dma_len       = '0;
      s_valid       = 1'b0;
      s_data        = '0;
      for (int i = 0; i < N; i++) exp_mem[i] = 16'h0000;

      // Reset state and combinational CPU path during reset.
      tick();
      tick();
      @(negedge mclk);
      chk("rst_busy", 32'(dma_busy), 32'd0);
      chk("rst_done", 32'(dma_done), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);
      chk("rst_ram_cen", 32'(ram_cen), 32'd1);
      chk("rst_ram_wen", 32'(ram_wen), 32'd3);
      tick();
      cpu_dmem_cen  = 1'b0;
      cpu_dmem_wen  = 2'b01;
      cpu_dmem_addr = 10'h2AA;
      cpu_dmem_din  = 16'h1234;
      @(negedge mclk);
      chk("rst_cpu_cen", 32'(ram_cen), 32'd0);
      chk("rst_cpu_wen", 32'(ram_wen), 32'd1);
      chk("rst_cpu_addr", 32'(ram_addr), 32'h2AA);
      chk("rst_cpu_din", 32'(ram_din), 32'h1234);
      tick();
      cpu_dmem_cen = 1'b1;
      cpu_dmem_wen = 2'b11;
      tick();
      clr     = 1'b0;
      puc_rst = 1'b0;
      tick();
      @(negedge mclk);
      chk("post_rst_busy", 32'(dma_busy), 32'd0);
      chk("post_rst_ready", 32'(s_ready), 32'd0);
      tick();

      // Basic transfer.
      wq = '{16'h1111, 16'h2222, 16'h3333};
      xfer(10'h010, 3, 1'b0);
      chk("basic_w0", 32'(mem[10'h010]), 32'(dma_word(16'h1111)));
      chk("basic_w2", 32'(mem[10'h012]), 32'(dma_word(16'h3333)));

      // CPU priority: FIFO holds two words while the CPU owns the RAM.
      n0 = done_n;
      w0 = dma_wr_n;
      start(10'h040, 11'd2);
      d = 16'($urandom);
      cpu_dmem_cen  = 1'b0;
      cpu_dmem_wen  = 2'b00;
      cpu_dmem_addr = 10'h200;
      cpu_dmem_din  = d;
      cpu_model_write(10'h200, d, 2'b00);
      push(16'($urandom), 10'h040, 1'b1);
      push(16'($urandom), 10'h041, 1'b1);
      snap = dma_wr_n;
      for (int i = 1; i <= 6; i++) begin
         d  = 16'($urandom);
         we = (i == 6) ? 2'b10 : 2'b00;
         cpu_dmem_addr = 10'(10'h200 + i);
         cpu_dmem_din  = d;
         cpu_dmem_wen  = we;
         cpu_model_write(10'(10'h200 + i), d, we);
         @(negedge mclk);
         chk("cpu_mux_addr", 32'(ram_addr), 32'(10'h200 + i));
         chk("cpu_mux_din", 32'(ram_din), 32'(d));
         tick();
      end
      chk("cpu_stall", 32'(dma_wr_n - snap), 32'd0);
      cpu_dmem_wen  = 2'b11;
      cpu_dmem_addr = 10'h203;
      tick();
      cpu_dmem_cen = 1'b1;
      @(negedge mclk);
      chk("cpu_read", 32'(cpu_dmem_dout), 32'(exp_mem[10'h203]));
      chk("cpu_byte_write", 32'(mem[10'h206]), 32'(exp_mem[10'h206]));
      xfer_check(10'h040, 2, n0, w0);

      // Backpressure with CPU busy, plus a start strobe that must be ignored.
      n0 = done_n;
      w0 = dma_wr_n;
      start(10'h080, 11'd8);
      cpu_dmem_cen  = 1'b0;
      cpu_dmem_wen  = 2'b11;
      cpu_dmem_addr = 10'h300;
      for (int i = 0; i < 4; i++) push(16'($urandom), 10'(10'h080 + i), 1'b1);
      @(negedge mclk);
      chk("bp_full_ready", 32'(s_ready), 32'd0);
      chk("bp_no_write", 32'(dma_wr_n - w0), 32'd0);
      start(10'h155, 11'd3);
      @(negedge mclk);
      chk("bp_busy", 32'(dma_busy), 32'd1);
      tick();
      cpu_dmem_cen = 1'b1;
      for (int i = 4; i < 8; i++) push(16'($urandom), 10'(10'h080 + i), 1'b1);
      @(negedge mclk);
      chk("bp_ready_after_len", 32'(s_ready), 32'd0);
      xfer_check(10'h080, 8, n0, w0);

      // Zero-length start.
      tick();
      n0 = done_n;
      w0 = dma_wr_n;
      start(10'h123, 11'd0);
      @(negedge mclk);
      chk("zero_done", 32'(dma_done), 32'd1);
      chk("zero_busy", 32'(dma_busy), 32'd0);
      tick();
      @(negedge mclk);
      chk("zero_done_pulse", 32'(dma_done), 32'd0);
      chk("zero_no_write", 32'(dma_wr_n - w0), 32'd0);
      tick();

      // Address wrap.
      xfer(10'h3FE, 4, 1'b1);
      chk("wrap_0", 32'(mem[10'h000]), 32'(exp_mem[10'h000]));
      chk("wrap_1", 32'(mem[10'h001]), 32'(exp_mem[10'h001]));

      // Reset mid-transfer with two words parked in the FIFO.
      n0 = done_n;
      start(10'h100, 11'd5);
      cpu_dmem_cen  = 1'b0;
      cpu_dmem_wen  = 2'b11;
      cpu_dmem_addr = 10'h300;
      push(16'($urandom), 10'h100, 1'b0);
      push(16'($urandom), 10'h101, 1'b0);
      w0 = dma_wr_n;
      puc_rst = 1'b1;
      @(negedge mclk);
      chk("abort_busy", 32'(dma_busy), 32'd0);
      chk("abort_ready", 32'(s_ready), 32'd0);
      chk("abort_done", 32'(dma_done), 32'd0);
      tick();
      puc_rst      = 1'b0;
      cpu_dmem_cen = 1'b1;
      s_valid      = 1'b1;
      s_data       = 16'($urandom);
      repeat (8) tick();
      @(negedge mclk);
      chk("abort_ready_after", 32'(s_ready), 32'd0);
      chk("abort_no_write", 32'(dma_wr_n - w0), 32'd0);
      chk("abort_no_done", 32'(done_n - n0), 32'd0);
      chk("abort_ram_kept", 32'(mem[10'h100]), 32'(exp_mem[10'h100]));
      tick();
      s_valid = 1'b0;
      xfer(10'h100, 2, 1'b1);

      // Byte order of the DMA write path.
      wq = '{16'hA55A};
      xfer(10'h020, 1, 1'b0);
`ifdef DMEM_DMA_BYTESWAP_EN
      chk("byteswap", 32'(mem[10'h020]), 32'h5AA5);
`else
      chk("byteswap", 32'(mem[10'h020]), 32'hA55A);
`endif

      // Randomized transfers.
      for (int k = 0; k < 5; k++)
         xfer(10'($urandom_range(0, 383)), int'($urandom_range(1, 6)), 1'b1);

      bad = 0;
      for (int i = 0; i < N; i++)
         if (mem[i] !== exp_mem[i]) bad++;
      chk("mem_image", 32'(bad), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_dma_bridge.md
Name: dmem_dma_bridge

Overview:
- Upstream stage of the data-memory RAM wrapper.
- Arbitrates the RAM port between the openMSP430 CPU data-memory interface and a streaming DMA write channel.
- Peripherals (e.g. sensor front-ends) push 16-bit words over a valid/ready stream. The block buffers them in a small FIFO and writes them to consecutive DMEM word addresses in cycles where the CPU does not access the RAM.
- The CPU always has priority and sees zero added wait states.

Parameters:
- ADDR_MSB, 9: MSB of the RAM word address; matches the DMEM address width.
- FIFO_DEPTH, 4: stream buffer depth in words; power of two, minimum 2.

Ports:
- mclk  in  1  system clock; all state on rising edge.
- puc_rst  in  1  reset, asynchronous, active-high.
- cpu_dmem_addr  in  ADDR_MSB+1  CPU RAM address.
- cpu_dmem_cen  in  1  CPU chip enable, low active.
- cpu_dmem_din  in  16  CPU write data.
- cpu_dmem_wen  in  2  CPU byte write enables, low active.
- cpu_dmem_dout  out  16  CPU read data.
- dma_start  in  1  one-cycle start strobe.
- dma_base_addr  in  ADDR_MSB+1  first word address, sampled at start.
- dma_len  in  ADDR_MSB+2  number of words to transfer, sampled at start.
- s_valid  in  1  stream word valid.
- s_data  in  16  stream word.
- s_ready  out  1  stream ready.
- dma_busy  out  1  transfer in progress.
- dma_done  out  1  one-cycle pulse at transfer completion.
- ram_addr  out  ADDR_MSB+1  to RAM.
- ram_cen  out  1  to RAM, low active.
- ram_din  out  16  to RAM.
- ram_wen  out  2  to RAM, low active.
- ram_dout  in  16  from RAM.

Behaviour:
- Reset values: dma_busy=0, dma_done=0, s_ready=0, FIFO empty, accept and write counters 0, state IDLE.
- RAM port outputs are combinational during reset: ram_cen=1 and ram_wen=2'b11 unless the CPU drives cen low.
- FSM has two states, IDLE and RUN.
- IDLE transitions:
  - On dma_start with dma_len!=0: latch base and len, clear counters, go to RUN.
  - On dma_start with dma_len==0: no RAM writes; dma_done pulses the next cycle; stay in IDLE.
- RUN behaviour:
  - dma_busy=1.
  - s_ready = (FIFO not full) && (accepted < len).
  - A word is accepted on s_valid && s_ready and pushed into the FIFO.
- RUN → IDLE transition:
  - Occurs on the edge that performs write number len.
  - dma_done=1 for exactly the following cycle.
  - dma_busy drops in that same cycle.
- dma_start while in RUN is ignored; latched parameters are unchanged.
- RAM mux is combinational, with no added latency on the CPU path:
  - cpu_dmem_cen==0: ram_addr/cen/din/wen = CPU signals. DMA write stalls; FIFO not popped.
  - Otherwise, FIFO non-empty in RUN: ram_cen=0, ram_wen=2'b00, ram_addr = current DMA address, ram_din = FIFO head. FIFO pops and the address increments on that edge.
  - Otherwise: ram_cen=1, ram_wen=2'b11, ram_addr=cpu_dmem_addr, ram_din=cpu_dmem_din.
- cpu_dmem_dout = ram_dout, passed straight through. CPU read data is valid the cycle after the access, as with a direct RAM connection.
- DMA address arithmetic is modulo 2^(ADDR_MSB+1): base + len beyond the top wraps to address 0.
- FIFO push and pop in the same cycle are both allowed; occupancy is unchanged.
- When the FIFO is full, s_ready=0 until a pop occurs.
- Reset asserted mid-transfer aborts immediately: FIFO is flushed and no dma_done is produced. Words already written stay in RAM.

Optional Feature:
- Macro: DMEM_DMA_BYTESWAP_EN.
- Defined: each DMA word is written as {s_data[7:0], s_data[15:8]}, for big-endian peripheral streams.
- Undefined: words are written exactly as received. The CPU path is unaffected in both cases.

Test Plan:
- Basic transfer: base=0x010, len=3, stream 0x1111/0x2222/0x3333 with CPU idle → RAM[0x010..0x012] hold those values; dma_done pulses once, one cycle after the third write; dma_busy is low in that cycle.
- CPU priority: CPU holds cen=0 for 6 cycles while the FIFO holds 2 words → no DMA write and no FIFO pop during those cycles; CPU writes and reads are correct; both DMA words land after CPU release.
- Backpressure: len=8, FIFO_DEPTH=4, CPU busy continuously → s_ready drops after 4 accepts; on CPU release, all 8 words land in order and s_ready deasserts after the 8th accept.
- Zero length and wrap:
  - len=0 → dma_done pulses the next cycle with no RAM write.
  - base=0x3FE, len=4 → writes go to 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-transfer: assert puc_rst after 2 of 5 words → busy/ready/done all 0 and FIFO empty; no further writes after reset release.
- Byte swap (DMEM_DMA_BYTESWAP_EN defined): stream 0xA55A → RAM holds 0x5AA5. With the macro undefined → RAM holds 0xA55A.
